// File: rtl/udp_echo.sv
// udp_echo: UDP loopback responder. Buffers one received UDP payload in a
// single-frame byte RAM, then returns it to the eth transmitter through the
// udp_tx_en / udp_tx_req handshake.
//
// Ports:
//   gmii_rx_clk      sole clock (eth rx and tx sides share it)
//   rst_n            synchronous active-low reset
//   udp_rx_data_vld  received payload byte valid
//   udp_rx_data      received payload byte
//   udp_rx_done      one-cycle end-of-datagram pulse
//   tx_rdy           eth transmitter idle
//   udp_tx_req       eth requests next payload byte
//   udp_tx_en        start pulse for a transmit frame (decoded from state and tx_rdy)
//   udp_tx_data_num  payload byte count of the frame being sent
//   udp_tx_data      payload byte, one cycle after its request
//   busy             high while a frame is held or being echoed
//   drop_cnt         (UDP_ECHO_STAT_EN only) dropped/truncated datagram count
//
// Optional feature macro: UDP_ECHO_STAT_EN adds drop_cnt.
module udp_echo #(
   parameter int unsigned DEPTH = 2048,
   parameter int unsigned AW    = 11
) (
   input  logic        gmii_rx_clk,
   input  logic        rst_n,
   input  logic        udp_rx_data_vld,
   input  logic [7:0]  udp_rx_data,
   input  logic        udp_rx_done,
   input  logic        tx_rdy,
   input  logic        udp_tx_req,
   output logic        udp_tx_en,
   output logic [15:0] udp_tx_data_num,
   output logic [7:0]  udp_tx_data,
   output logic        busy
`ifdef UDP_ECHO_STAT_EN
   ,
   output logic [15:0] drop_cnt
`endif
);

   // Counters need one extra bit so they can hold DEPTH itself
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RECV  = 3'd1,
      START = 3'd2,
      SEND  = 3'd3,
      DRAIN = 3'd4
   } state_t;

   state_t         state, state_nxt;
   logic [CW-1:0]  wr_cnt, wr_cnt_nxt;
   logic [CW-1:0]  rd_cnt, rd_cnt_nxt;
   logic [15:0]    num_nxt;
   logic           skip, skip_nxt;
   logic           we;
   logic [AW-1:0]  waddr;
   logic           re;
   logic           full;
   logic           tx_side;

   logic [7:0]     mem [DEPTH];

   assign full    = (wr_cnt == CW'(DEPTH));
   assign tx_side = (state == START) || (state == SEND) || (state == DRAIN);
   assign busy    = (state != IDLE);

   // Next-state, counter and handshake decode
   always_comb begin
      state_nxt  = state;
      wr_cnt_nxt = wr_cnt;
      rd_cnt_nxt = rd_cnt;
      num_nxt    = udp_tx_data_num;
      skip_nxt   = skip;
      we         = 1'b0;
      waddr      = wr_cnt[AW-1:0];
      re         = 1'b0;
      udp_tx_en  = 1'b0;

      case (state)
         IDLE: begin
            if (skip) begin
               // tail of a frame that started while we were transmitting
               if (udp_rx_done) skip_nxt = 1'b0;
            end else if (udp_rx_data_vld) begin
               we         = 1'b1;
               waddr      = '0;
               wr_cnt_nxt = CW'(1);
               if (udp_rx_done) begin
                  num_nxt   = 16'(1);
                  state_nxt = START;
               end else begin
                  state_nxt = RECV;
               end
            end
         end
         RECV: begin
            if (udp_rx_data_vld && !full) begin
               we         = 1'b1;
               wr_cnt_nxt = wr_cnt + CW'(1);
            end
            // a byte arriving with done is already counted in wr_cnt_nxt
            if (udp_rx_done) begin
               num_nxt   = 16'(wr_cnt_nxt);
               state_nxt = (wr_cnt_nxt == '0) ? IDLE : START;
            end
         end
         START: begin
            if (tx_rdy) begin
               udp_tx_en = 1'b1;
               state_nxt = SEND;
            end
         end
         SEND: begin
            if (udp_tx_req) begin
               re         = 1'b1;
               rd_cnt_nxt = rd_cnt + CW'(1);
               if (16'(rd_cnt_nxt) >= udp_tx_data_num) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      // Datagrams starting while the buffer is busy transmitting are dropped whole
      if (tx_side) begin
         if (udp_rx_done)          skip_nxt = 1'b0;
         else if (udp_rx_data_vld) skip_nxt = 1'b1;
      end

      if ((state_nxt == IDLE) && (state != IDLE)) begin
         wr_cnt_nxt = '0;
         rd_cnt_nxt = '0;
      end
   end

   // State and control registers
   always_ff @(posedge gmii_rx_clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         wr_cnt          <= '0;
         rd_cnt          <= '0;
         udp_tx_data_num <= '0;
         skip            <= 1'b0;
      end else begin
         state           <= state_nxt;
         wr_cnt          <= wr_cnt_nxt;
         rd_cnt          <= rd_cnt_nxt;
         udp_tx_data_num <= num_nxt;
         skip            <= skip_nxt;
      end
   end

   // Payload buffer write port (contents deliberately not reset)
   always_ff @(posedge gmii_rx_clk) begin
      if (rst_n && we) mem[waddr] <= udp_rx_data;
   end

   // Registered read port; output holds when no request is accepted
   always_ff @(posedge gmii_rx_clk) begin
      if (!rst_n) begin
         udp_tx_data <= '0;
      end else if (re) begin
         udp_tx_data <= mem[rd_cnt[AW-1:0]];
      end
   end

`ifdef UDP_ECHO_STAT_EN
   logic ovf;
   logic skip_drop;
   logic ovf_drop;

   assign skip_drop = udp_rx_done &&
                      (((state == IDLE) && skip) || (tx_side && (skip || udp_rx_data_vld)));
   assign ovf_drop  = (state == RECV) && udp_rx_done &&
                      (ovf || (udp_rx_data_vld && full));

   // Overflow tracking and saturating drop counter
   always_ff @(posedge gmii_rx_clk) begin
      if (!rst_n) begin
         ovf      <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (state_nxt != RECV)                       ovf <= 1'b0;
         else if ((state == RECV) && udp_rx_data_vld && full) ovf <= 1'b1;
         if ((skip_drop || ovf_drop) && (drop_cnt != 16'hFFFF))
            drop_cnt <= drop_cnt + 16'(1);
      end
   end
`endif

endmodule

// File: tb/tb_udp_echo.sv
// tb_udp_echo: directed plus randomized bench for udp_echo. The reference
// model is a byte queue of the sent payload; the expected echo is its first
// min(len, DEPTH) bytes.
module tb_udp_echo;

   localparam int unsigned DEPTH = 64;
   localparam int unsigned AW    = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        udp_rx_data_vld;
   logic [7:0]  udp_rx_data;
   logic        udp_rx_done;
   logic        tx_rdy;
   logic        udp_tx_req;
   logic        udp_tx_en;
   logic [15:0] udp_tx_data_num;
   logic [7:0]  udp_tx_data;
   logic        busy;
`ifdef UDP_ECHO_STAT_EN
   logic [15:0] drop_cnt;
   int          drop_exp = 0;
`endif

   int checks   = 0;
   int errors   = 0;
   int en_count = 0;
   logic [7:0] pay [$];

   always #5 clk = ~clk;

   udp_echo #(.DEPTH(DEPTH), .AW(AW)) dut (
      .gmii_rx_clk     (clk),
      .rst_n           (rst_n),
      .udp_rx_data_vld (udp_rx_data_vld),
      .udp_rx_data     (udp_rx_data),
      .udp_rx_done     (udp_rx_done),
      .tx_rdy          (tx_rdy),
      .udp_tx_req      (udp_tx_req),
      .udp_tx_en       (udp_tx_en),
      .udp_tx_data_num (udp_tx_data_num),
      .udp_tx_data     (udp_tx_data),
      .busy            (busy)
`ifdef UDP_ECHO_STAT_EN
      ,
      .drop_cnt        (drop_cnt)
`endif
   );

   // Count every start pulse, sampled mid-cycle
   always @(negedge clk) if (rst_n && udp_tx_en) en_count++;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic fill_rand(input int len);
      pay.delete();
      for (int i = 0; i < len; i++) pay.push_back(8'($urandom));
   endtask

   // Send the payload queue as one datagram; returns in the cycle after done
   task automatic rx_frame(input int len, input bit done_last);
      for (int i = 0; i < len; i++) begin
         udp_rx_data_vld = 1'b1;
         udp_rx_data     = pay[i];
         udp_rx_done     = done_last && (i == len - 1);
         tick();
         if (i == 0) chk("busy_rx", 32'(busy), 32'd1);
      end
      udp_rx_data_vld = 1'b0;
      if (!done_last) begin
         udp_rx_done = 1'b1;
         tick();
      end
      udp_rx_done = 1'b0;
   endtask

   // Expect the echo of the current payload. mid: bytes of an interfering
   // datagram sent during SEND; tail: interfering bytes starting in DRAIN.
   task automatic echo(input int len, input int rdy_delay, input int gap_mode,
                       input int mid, input int tail);
      int n;
      int e0;
      int g;
      n  = (len > int'(DEPTH)) ? int'(DEPTH) : len;
      e0 = en_count;
      for (int k = 0; k < rdy_delay; k++) begin
         tx_rdy = 1'b0;
         #1;
         chk("tx_en_wait", 32'(udp_tx_en), 32'd0);
         if (k == 0) chk("busy_start", 32'(busy), 32'd1);
         tick();
      end
      tx_rdy = 1'b1;
      #1;
      chk("tx_en", 32'(udp_tx_en), 32'd1);
      chk("data_num", 32'(udp_tx_data_num), 32'(n));
      tick();
      chk("en_pulses", 32'(en_count), 32'(e0 + 1));
      chk("tx_en_single", 32'(udp_tx_en), 32'd0);
      if (mid > 0) begin
         for (int m = 0; m < mid; m++) begin
            udp_rx_data_vld = 1'b1;
            udp_rx_data     = 8'($urandom);
            tick();
         end
         udp_rx_data_vld = 1'b0;
         udp_rx_done     = 1'b1;
         tick();
         udp_rx_done     = 1'b0;
         chk("busy_send", 32'(busy), 32'd1);
`ifdef UDP_ECHO_STAT_EN
         drop_exp++;
`endif
      end
      for (int i = 0; i < n; i++) begin
         udp_tx_req = 1'b1;
         tick();
         udp_tx_req = 1'b0;
         chk("tx_data", 32'(udp_tx_data), 32'(pay[i]));
         if (i < n - 1) begin
            g = (gap_mode < 0) ? int'($urandom_range(3, 0)) : gap_mode;
            for (int k = 0; k < g; k++) begin
               tick();
               chk("tx_data_hold", 32'(udp_tx_data), 32'(pay[i]));
            end
         end
      end
      chk("busy_drain", 32'(busy), 32'd1);
      chk("data_num_stable", 32'(udp_tx_data_num), 32'(n));
      if (tail > 0) begin
         for (int t = 0; t < tail; t++) begin
            udp_rx_data_vld = 1'b1;
            udp_rx_data     = 8'($urandom);
            if (t > 0) chk("busy_skip", 32'(busy), 32'd0);
            tick();
         end
         udp_rx_data_vld = 1'b0;
         udp_rx_done     = 1'b1;
         chk("busy_skip_done", 32'(busy), 32'd0);
         tick();
         udp_rx_done     = 1'b0;
`ifdef UDP_ECHO_STAT_EN
         drop_exp++;
`endif
      end else begin
         tick();
      end
      chk("busy_fall", 32'(busy), 32'd0);
      udp_tx_req = 1'b1;
      tick();
      udp_tx_req = 1'b0;
      chk("data_after_extra_req", 32'(udp_tx_data), 32'(pay[n-1]));
      chk("busy_idle", 32'(busy), 32'd0);
      tick();
      chk("no_extra_en", 32'(en_count), 32'(e0 + 1));
`ifdef UDP_ECHO_STAT_EN
      if (len > int'(DEPTH)) drop_exp++;
      chk("drop_cnt", 32'(drop_cnt), 32'(drop_exp));
`endif
   endtask

   initial begin
      int len;
      int e0;
      rst_n           = 1'b0;
      udp_rx_data_vld = 1'b0;
      udp_rx_data     = '0;
      udp_rx_done     = 1'b0;
      tx_rdy          = 1'b1;
      udp_tx_req      = 1'b0;
      tick();
      tick();
      chk("rst_tx_en", 32'(udp_tx_en), 32'd0);
      chk("rst_num", 32'(udp_tx_data_num), 32'd0);
      chk("rst_data", 32'(udp_tx_data), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      rst_n = 1'b1;
      tick();

      // 18-byte incrementing payload, contiguous requests
      pay.delete();
      for (int i = 0; i < 18; i++) pay.push_back(8'(i));
      rx_frame(18, 1'b0);
      echo(18, 0, 0, 0, 0);

      // transmitter busy for 50 cycles after done
      fill_rand(7);
      rx_frame(7, 1'b0);
      echo(7, 50, 0, 0, 0);

      // gapped requests, 1 on 2 off
      pay.delete();
      for (int i = 0; i < 5; i++) pay.push_back(8'(8'hA1 + i));
      rx_frame(5, 1'b0);
      echo(5, 0, 2, 0, 0);

      // second 10-byte datagram arriving during SEND
      fill_rand(12);
      rx_frame(12, 1'b0);
      echo(12, 0, 1, 10, 0);

      // datagram starting in DRAIN and continuing into IDLE
      fill_rand(9);
      rx_frame(9, 1'b1);
      echo(9, 0, 0, 0, 6);

      // overflow: 100 bytes into a 64-byte buffer
      fill_rand(100);
      rx_frame(100, 1'b0);
      echo(100, 0, 0, 0, 0);

      // lone done in IDLE is ignored
      e0 = en_count;
      udp_rx_done = 1'b1;
      tick();
      udp_rx_done = 1'b0;
      chk("done_idle_busy", 32'(busy), 32'd0);
      tick();
      chk("done_idle_en", 32'(en_count), 32'(e0));

      // reset in the middle of RECV
      fill_rand(7);
      for (int i = 0; i < 3; i++) begin
         udp_rx_data_vld = 1'b1;
         udp_rx_data     = pay[i];
         tick();
      end
      udp_rx_data_vld = 1'b0;
      rst_n = 1'b0;
      e0 = en_count;
      tick();
      rst_n = 1'b1;
      #1;
      chk("rst_mid_tx_en", 32'(udp_tx_en), 32'd0);
      chk("rst_mid_num", 32'(udp_tx_data_num), 32'd0);
      chk("rst_mid_data", 32'(udp_tx_data), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
`ifdef UDP_ECHO_STAT_EN
      drop_exp = 0;
      chk("rst_mid_drop", 32'(drop_cnt), 32'd0);
`endif
      tick();
      chk("rst_mid_no_en", 32'(en_count), 32'(e0));
      pay.delete();
      pay.push_back(8'hDE);
      pay.push_back(8'hAD);
      pay.push_back(8'hBE);
      pay.push_back(8'hEF);
      rx_frame(4, 1'b0);
      echo(4, 0, 0, 0, 0);

      // randomized datagrams
      for (int r = 0; r < 10; r++) begin
         len = int'($urandom_range(80, 1));
         fill_rand(len);
         rx_frame(len, 1'($urandom_range(1, 0)));
         echo(len, int'($urandom_range(4, 0)), -1,
              int'($urandom_range(1, 0)) * int'($urandom_range(4, 1)),
              int'($urandom_range(3, 0)));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/udp_echo.md
# udp_echo

User-side UDP responder between the `eth` block's UDP receive outputs and its UDP transmit inputs. Stores each received UDP payload in a single-frame byte buffer, then sends it back to the host through the `udp_tx_en` / `udp_tx_req` handshake. This gives the board a self-contained UDP loopback for link bring-up and throughput checks. One clock domain; the `eth` transmit and receive clocks are driven from the same net.

## Interface
- `DEPTH`, 2048: payload buffer size in bytes (power of two, ≥ 64).
- `AW`, 11: buffer address width, log2(`DEPTH`).

Ports (clock and reset first):
- `gmii_rx_clk`  in  1  sole clock; `eth` UDP rx and tx sides share it.
- `rst_n`  in  1  reset; synchronous, active-low.
- `udp_rx_data_vld`  in  1  received payload byte valid.
- `udp_rx_data`  in  8  received payload byte.
- `udp_rx_done`  in  1  one-cycle pulse, end of received datagram.
- `tx_rdy`  in  1  `eth` transmitter idle.
- `udp_tx_req`  in  1  `eth` requests next payload byte.
- `udp_tx_en`  out  1  one-cycle start pulse for a transmit frame.
- `udp_tx_data_num`  out  16  payload byte count of the frame being sent.
- `udp_tx_data`  out  8  payload byte; lags `udp_tx_req` by exactly 1 cycle.
- `busy`  out  1  high from first stored byte until the echo completes.

## Operation
- State machine: IDLE, RECV, START, SEND, DRAIN.
- IDLE: first `udp_rx_data_vld` goes to RECV. That byte is written to address 0 and `wr_cnt` becomes 1.
- RECV: each valid byte is written at `wr_cnt` and `wr_cnt` increments. When `wr_cnt` = `DEPTH`, further bytes are discarded and `wr_cnt` saturates at `DEPTH`.
- RECV exit on `udp_rx_done`:
  - `udp_tx_data_num` latches the final `wr_cnt`, zero-extended to 16 bits.
  - If `vld` and `done` arrive in the same cycle, the byte is counted first.
  - If the count is 0, the block returns to IDLE; otherwise it goes to START.
- START: waits for `tx_rdy` = 1, then pulses `udp_tx_en` for 1 cycle and goes to SEND.
- SEND: each `udp_tx_req` cycle performs a registered buffer read at `rd_cnt` and increments `rd_cnt`. When `rd_cnt` reaches `udp_tx_data_num`, the block goes to DRAIN.
  - Requests beyond the count are ignored and the data output holds.
- DRAIN: 1 cycle while the last byte is presented, then IDLE. `rd_cnt` and `wr_cnt` clear on IDLE entry.
- Frames arriving in START, SEND or DRAIN are dropped whole:
  - A `skip` flag is set on a `vld` seen outside IDLE/RECV.
  - Bytes are ignored while `skip` = 1.
  - `skip` clears on the next `udp_rx_done`.
  - A frame already in progress when IDLE is re-entered stays dropped until its `done`.
- `udp_rx_done` in IDLE with no bytes received: ignored.

## Timing
- Reset values: `udp_tx_en` = 0, `udp_tx_data_num` = 0, `udp_tx_data` = 0, `busy` = 0, state IDLE, `skip` = 0, both counters 0.
- Reset mid-frame aborts immediately; the partial frame is lost and no `udp_tx_en` is issued.
- The buffer is inferred single-clock RAM with 1-cycle read latency. Buffer contents are not reset.
- Latency, in the best case with `tx_rdy` already high:
  - `udp_rx_done` at cycle T: state is START from T+1.
  - `udp_tx_en` at T+1; state is SEND from T+2.
- Data rule: `udp_tx_req` at cycle N gives `udp_tx_data` at N+1. Requests may be non-contiguous.
- `udp_tx_data_num` is stable from the `udp_tx_en` cycle until return to IDLE.
- `busy` = 1 in RECV, START, SEND and DRAIN (excluding frames being skipped); 0 in IDLE.

## Configuration
- `UDP_ECHO_STAT_EN` defined:
  - Adds output `drop_cnt` (16 bits, reset 0).
  - It increments once per datagram dropped because of `skip`, and once per datagram truncated by overflow.
  - It saturates at 16'hFFFF.
- `UDP_ECHO_STAT_EN` undefined: the `drop_cnt` port and its logic are absent; behaviour is otherwise identical.

## Test plan
- 18-byte payload 0x00..0x11, `tx_rdy` = 1:
  - one `udp_tx_en` pulse, 1 cycle after `udp_rx_done`, with `udp_tx_data_num` = 18;
  - 18 contiguous requests give bytes 0x00..0x11, each 1 cycle after its request;
  - `busy` falls 1 cycle after the last byte.
- `tx_rdy` held 0 for 50 cycles after `done`:
  - `udp_tx_en` stays 0 and the block waits in START;
  - `tx_rdy` rises at cycle 50, and `udp_tx_en` pulses in that same cycle.
- Requests gapped (1 on, 2 off), 5-byte frame 0xA1..0xA5: each byte appears exactly 1 cycle after its request, and the output holds between requests.
- Second 10-byte datagram received during SEND of the first:
  - only the first frame is echoed; no second `udp_tx_en` is issued;
  - with the macro defined, `drop_cnt` = 1.
- `DEPTH` = 64 with a 100-byte payload: `udp_tx_data_num` = 64, bytes 0..63 are echoed, and (with the macro) `drop_cnt` = 1.
- `rst_n` = 0 for 1 cycle in the middle of RECV, then a 4-byte frame 0xDE,0xAD,0xBE,0xEF:
  - all outputs are 0 in the cycle after reset;
  - only the 4-byte frame is echoed, with `udp_tx_data_num` = 4.
